aer_rate_encoder: RTL and testbench

- Upstream input stage of the SNN core.
- Holds one sample of pixel intensities in a local buffer and rate-codes it over TIME_STEP time steps.
- Emits one AER event per input spike, plus one time-step tick event, through a 4-phase REQ/ACK handshake.
- Drives the core's AERIN_ADDR/AERIN_REQ/AERIN_ACK pins, then waits for the core's sample-done pulse before reporting completion.

---
 rtl/aer_rate_encoder.sv | 206 ++++++++++++++++++++
 tb/tb_aer_rate_encoder.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_rate_encoder.sv
// aer_rate_encoder: buffers one pixel sample and rate-codes it into AER events.
// Define AER_ENC_LFSR_EN for stochastic (LFSR) spike generation.
// Ports: CLK, RST_N (async, active low);
//   PIX_WE/PIX_ADDR/PIX_DATA load the pixel buffer while idle;
//   START begins a sample; AEROUT_ADDR/AEROUT_REQ/AEROUT_ACK form the
//   4-phase event link; CORE_DONE ends the sample; BUSY, DONE, EVT_CNT status.
module aer_rate_encoder #(
  parameter int          TIME_STEP      = 8,
  parameter int          INPUT_NEURON   = 784,
  parameter int          AER_WIDTH      = 12,
  parameter int          PIX_WIDTH      = 8,
  parameter int          PIX_ADDR_WIDTH = 10,
  parameter int unsigned TICK_ADDR      = 12'hFFF
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      PIX_WE,
  input  logic [PIX_ADDR_WIDTH-1:0] PIX_ADDR,
  input  logic [PIX_WIDTH-1:0]      PIX_DATA,
  input  logic                      START,
  output logic [AER_WIDTH-1:0]      AEROUT_ADDR,
  output logic                      AEROUT_REQ,
  input  logic                      AEROUT_ACK,
  input  logic                      CORE_DONE,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [15:0]               EVT_CNT
);

  localparam int TW = $clog2(TIME_STEP);

  typedef enum logic [3:0] {
    IDLE,
    SCAN,
    EVAL,
    REQ,
    REL,
    TICK,
    TICK_REL,
    WAIT_CORE,
    DONE_ST
  } state_t;

  state_t                    state_q, state_d;
  logic [PIX_ADDR_WIDTH-1:0] n_q, n_d;
  logic [TW-1:0]             t_q, t_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [AER_WIDTH-1:0]      addr_q, addr_d;
  logic                      req_q, req_d;

  logic [PIX_WIDTH-1:0]      mem_q [INPUT_NEURON];
  logic [PIX_WIDTH-1:0]      rdata_q;

  logic busy;
  logic start_go;
  logic we;
  logic fire;
  logic last_pix;
  logic last_step;

  assign busy      = (state_q != IDLE) && (state_q != DONE_ST);
  assign start_go  = START && !busy;
  assign we        = PIX_WE && !busy
                   && (int'(PIX_ADDR) < INPUT_NEURON);
  assign last_pix  = (n_q == PIX_ADDR_WIDTH'(INPUT_NEURON - 1));
  assign last_step = (t_q == TW'(TIME_STEP - 1));

  // Pixel buffer: never reset, one-cycle read issued from SCAN.
  always_ff @(posedge CLK) begin
    if (we) mem_q[PIX_ADDR] <= PIX_DATA;
    if (state_q == SCAN) rdata_q <= mem_q[n_q];
  end

`ifdef AER_ENC_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11; one step per pixel evaluation.
  always_comb begin
    lfsr_d = lfsr_q;
    if (start_go) begin
      lfsr_d = 16'hACE1;
    end else if (state_q == EVAL) begin
      lfsr_d = {lfsr_q[14:0],
                lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  // Strict compare keeps a zero pixel silent.
  assign fire = rdata_q > lfsr_q[PIX_WIDTH-1:0];
`else
  localparam int PRW = PIX_WIDTH + TW + 1;

  logic [PRW-1:0] prod_lo, prod_hi;

  // Fires when the integer part of p*t/2^PIX_WIDTH steps up.
  assign prod_lo = PRW'(rdata_q) * PRW'(t_q);
  assign prod_hi = PRW'(rdata_q) * (PRW'(t_q) + PRW'(1));
  assign fire    = prod_hi[PRW-1:PIX_WIDTH]
                 > prod_lo[PRW-1:PIX_WIDTH];
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE, DONE_ST: begin
        state_d = IDLE;
        if (START) begin
          state_d = SCAN;
          n_d     = '0;
          t_d     = '0;
          cnt_d   = '0;
        end
      end
      SCAN: state_d = EVAL;
      EVAL: begin
        if (fire) begin
          state_d = REQ;
          addr_d  = AER_WIDTH'(n_q);
        end else if (last_pix) begin
          state_d = TICK;
          addr_d  = AER_WIDTH'(TICK_ADDR);
        end else begin
          state_d = SCAN;
          n_d     = n_q + 1'b1;
        end
      end
      // REQ only rises once ACK is seen low; a stale ACK is not consumed.
      REQ: begin
        if (!req_q) begin
          if (!AEROUT_ACK) req_d = 1'b1;
        end else if (AEROUT_ACK) begin
          req_d   = 1'b0;
          state_d = REL;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
      end
      REL: begin
        if (!AEROUT_ACK) begin
          if (last_pix) begin
            state_d = TICK;
            addr_d  = AER_WIDTH'(TICK_ADDR);
          end else begin
            state_d = SCAN;
            n_d     = n_q + 1'b1;
          end
        end
      end
      TICK: begin
        if (!req_q) begin
          if (!AEROUT_ACK) req_d = 1'b1;
        end else if (AEROUT_ACK) begin
          req_d   = 1'b0;
          state_d = TICK_REL;
        end
      end
      TICK_REL: begin
        if (!AEROUT_ACK) begin
          if (last_step) begin
            state_d = WAIT_CORE;
          end else begin
            state_d = SCAN;
            t_d     = t_q + 1'b1;
            n_d     = '0;
          end
        end
      end
      WAIT_CORE: if (CORE_DONE) state_d = DONE_ST;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      n_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  assign AEROUT_ADDR = addr_q;
  assign AEROUT_REQ  = req_q;
  assign BUSY        = busy;
  assign DONE        = (state_q == DONE_ST);
  assign EVT_CNT     = cnt_q;

endmodule

// File: tb/tb_aer_rate_encoder.sv
// tb_aer_rate_encoder: scoreboard bench for aer_rate_encoder.
// Expected AER event streams come from the spike-rule model below.
module tb_aer_rate_encoder;

  localparam int          TS   = 8;
  localparam int          NPIX = 784;
  localparam logic [11:0] TICK = 12'hFFF;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        pix_we = 0;
  logic [9:0]  pix_addr = 0;
  logic [7:0]  pix_data = 0;
  logic        start = 0;
  logic        ack = 0;
  logic        core_done = 0;
  logic [11:0] aer_addr;
  logic        req;
  logic        busy;
  logic        done;
  logic [15:0] evt_cnt;

  int checks = 0;
  int errors = 0;

  int          pix_m [NPIX];
  logic [11:0] exp_q [$];
  logic [11:0] got_q [$];

  int   viol;
  bit   timeout;
  logic done_pre, busy_pre, done_hit, busy_hit, done_after;

  always #5 clk = ~clk;

  aer_rate_encoder dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .PIX_WE      (pix_we),
    .PIX_ADDR    (pix_addr),
    .PIX_DATA    (pix_data),
    .START       (start),
    .AEROUT_ADDR (aer_addr),
    .AEROUT_REQ  (req),
    .AEROUT_ACK  (ack),
    .CORE_DONE   (core_done),
    .BUSY        (busy),
    .DONE        (done),
    .EVT_CNT     (evt_cnt)
  );

  task automatic load_pix(input int a, input int d);
    @(negedge clk);
    pix_we   = 1;
    pix_addr = 10'(a);
    pix_data = 8'(d);
    if (a < NPIX) pix_m[a] = d;
  endtask

  task automatic load_end();
    @(negedge clk);
    pix_we = 0;
  endtask

  // Scoreboard: expected event order for the current model contents.
  task automatic build_exp();
    exp_q.delete();
    for (int t = 0; t < TS; t++) begin
      for (int p = 0; p < NPIX; p++) begin
        if ((pix_m[p] * (t + 1)) / 256 > (pix_m[p] * t) / 256)
          exp_q.push_back(12'(p));
      end
      exp_q.push_back(TICK);
    end
  endtask

  function automatic int exp_spikes();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i] != TICK) n++;
    return n;
  endfunction

  function automatic int first_diff();
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [11:0] q_at(input logic [11:0] q [$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 12'h000;
  endfunction

  // Acts as the core: answers each REQ after dly cycles, records addresses,
  // then pulses CORE_DONE and samples DONE/BUSY around it.
  task automatic run_sample(input int dly, input bit ack_pre,
                            input bit disturb, input int budget);
    int rs, cnt, ticks, cyc, pre;
    bit prev_req;
    logic [11:0] held;
    got_q.delete();
    viol = 0; timeout = 0; ticks = 0; pre = 0; cnt = 0;
    prev_req = 0; held = 0; cyc = 0;
    rs = ack_pre ? 4 : 0;
    pix_we = 0;
    @(negedge clk);
    start = 1;
    if (ack_pre) ack = 1;
    @(negedge clk);
    start = 0;
    while (!(ticks == TS && rs == 0 && !req)) begin
      if (cyc >= budget) begin
        timeout = 1;
        break;
      end
      if (req && prev_req && aer_addr !== held) viol++;
      if (req && !prev_req) begin
        if (ack) viol++;
        got_q.push_back(aer_addr);
        if (aer_addr == TICK) ticks++;
      end
      held = aer_addr;
      prev_req = req;
      if (disturb && cyc == 50) begin
        start = 1; pix_we = 1; pix_addr = 9; pix_data = 255;
        core_done = 1;
      end else begin
        start = 0; pix_we = 0; core_done = 0;
      end
      case (rs)
        0: if (req) begin
          cnt = 0;
          if (dly == 0) begin ack = 1; rs = 2; end
          else rs = 1;
        end
        1: if (cnt + 1 >= dly) begin ack = 1; rs = 2; end else cnt++;
        2: if (!req) begin rs = 3; cnt = 0; end
        3: if (cnt >= dly) begin ack = 0; rs = 0; end else cnt++;
        default: begin
          if (req) viol++;
          if (pre >= 6) begin ack = 0; rs = 0; end else pre++;
        end
      endcase
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    done_pre = done;
    busy_pre = busy;
    core_done = 1;
    @(negedge clk);
    done_hit = done;
    busy_hit = busy;
    core_done = 0;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (aer_addr !== 12'h000) begin
      errors++; $display("FAIL rst_addr got %0h want 0", aer_addr);
    end
    checks++;
    if (req !== 1'b0) begin
      errors++; $display("FAIL rst_req got %0b want 0", req);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %0b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL rst_done got %0b want 0", done);
    end
    checks++;
    if (evt_cnt !== 16'h0) begin
      errors++; $display("FAIL rst_evt got %0d want 0", evt_cnt);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_all_zero();
    int d;
    for (int p = 0; p < NPIX; p++) load_pix(p, 0);
    load_pix(900, 77);
    load_end();
    build_exp();
    run_sample(2, 0, 0, 40000);
    d = first_diff();
    checks++;
    if (timeout) begin
      errors++; $display("FAIL zero_timeout got 1 want 0");
    end
    checks++;
    if (got_q.size() != TS) begin
      errors++; $display("FAIL zero_count got %0d want %0d", got_q.size(), TS);
    end
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL zero_seq idx %0d got %0h want %0h",
               d, q_at(got_q, d), q_at(exp_q, d));
    end
    checks++;
    if (evt_cnt !== 16'd0) begin
      errors++; $display("FAIL zero_evt got %0d want 0", evt_cnt);
    end
    checks++;
    if (done_pre !== 1'b0 || busy_pre !== 1'b1) begin
      errors++;
      $display("FAIL zero_wait got done %0b busy %0b want done 0 busy 1",
               done_pre, busy_pre);
    end
    checks++;
    if (done_hit !== 1'b1 || busy_hit !== 1'b0) begin
      errors++;
      $display("FAIL zero_done got done %0b busy %0b want done 1 busy 0",
               done_hit, busy_hit);
    end
    checks++;
    if (done_after !== 1'b0) begin
      errors++; $display("FAIL zero_done_pulse got %0b want 0", done_after);
    end
  endtask

  task automatic test_two_pixel();
    int d;
    load_pix(5, 128);
    load_pix(9, 32);
    load_end();
    build_exp();
    run_sample(2, 0, 1, 40000);
    d = first_diff();
    checks++;
    if (timeout) begin
      errors++; $display("FAIL two_timeout got 1 want 0");
    end
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL two_seq idx %0d got %0h want %0h",
               d, q_at(got_q, d), q_at(exp_q, d));
    end
    checks++;
    if (evt_cnt !== 16'(exp_spikes())) begin
      errors++;
      $display("FAIL two_evt got %0d want %0d", evt_cnt, exp_spikes());
    end
    checks++;
    if (done_hit !== 1'b1) begin
      errors++; $display("FAIL two_done got %0b want 1", done_hit);
    end
  endtask

  task automatic test_last_pixel();
    int d;
    load_pix(5, 0);
    load_pix(9, 0);
    load_pix(783, 255);
    load_end();
    build_exp();
    run_sample(2, 0, 0, 40000);
    d = first_diff();
    checks++;
    if (timeout) begin
      errors++; $display("FAIL last_timeout got 1 want 0");
    end
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL last_seq idx %0d got %0h want %0h",
               d, q_at(got_q, d), q_at(exp_q, d));
    end
    checks++;
    if (evt_cnt !== 16'd7) begin
      errors++; $display("FAIL last_evt got %0d want 7", evt_cnt);
    end
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL last_hs got %0d violations want 0", viol);
    end
  endtask

  task automatic test_ack_stress();
    int d;
    build_exp();
    run_sample(6, 1, 0, 60000);
    d = first_diff();
    checks++;
    if (timeout) begin
      errors++; $display("FAIL ack_timeout got 1 want 0");
    end
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL ack_hs got %0d violations want 0", viol);
    end
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL ack_seq idx %0d got %0h want %0h",
               d, q_at(got_q, d), q_at(exp_q, d));
    end
    checks++;
    if (evt_cnt !== 16'(exp_spikes())) begin
      errors++;
      $display("FAIL ack_evt got %0d want %0d", evt_cnt, exp_spikes());
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int d;
    load_pix(783, 0);
    load_pix(0, 255);
    load_end();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    found = 0;
    for (int c = 0; c < 5000 && !found; c++) begin
      if (req && aer_addr == 12'h000) begin
        found = 1;
      end else begin
        ack = req;
        @(negedge clk);
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL mid_reach got no REQ for addr 0 want one");
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got req %0b busy %0b want req 0 busy 0",
               req, busy);
    end
    checks++;
    if (evt_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_evt_rst got %0d want 0", evt_cnt);
    end
    ack = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    build_exp();
    run_sample(2, 0, 0, 40000);
    d = first_diff();
    checks++;
    if (q_at(got_q, 0) !== TICK) begin
      errors++;
      $display("FAIL mid_first got %0h want %0h", q_at(got_q, 0), TICK);
    end
    checks++;
    if (timeout || d != -1) begin
      errors++;
      $display("FAIL mid_seq idx %0d got %0h want %0h",
               d, q_at(got_q, d), q_at(exp_q, d));
    end
    checks++;
    if (evt_cnt !== 16'd7) begin
      errors++; $display("FAIL mid_evt got %0d want 7", evt_cnt);
    end
  endtask

`ifdef AER_ENC_LFSR_EN
  task automatic test_lfsr();
    int n;
    for (int p = 0; p < NPIX; p++) load_pix(p, 255);
    load_end();
    run_sample(0, 0, 0, 90000);
    checks++;
    if (timeout) begin
      errors++; $display("FAIL lfsr_timeout got 1 want 0");
    end
    n = 0;
    foreach (got_q[i]) begin
      if (got_q[i] == TICK) begin
        checks++;
        if (n < 775 || n > 784) begin
          errors++; $display("FAIL lfsr_step got %0d want 775..784", n);
        end
        n = 0;
      end else begin
        n++;
      end
    end
    for (int p = 0; p < NPIX; p++) load_pix(p, 0);
    load_end();
    exp_q.delete();
    for (int t = 0; t < TS; t++) exp_q.push_back(TICK);
    run_sample(0, 0, 0, 40000);
    n = first_diff();
    checks++;
    if (timeout || n != -1) begin
      errors++;
      $display("FAIL lfsr_zero idx %0d got %0h want %0h",
               n, q_at(got_q, n), q_at(exp_q, n));
    end
  endtask
`endif

  initial begin
    for (int p = 0; p < NPIX; p++) pix_m[p] = 0;
    test_reset();
`ifdef AER_ENC_LFSR_EN
    test_lfsr();
`else
    test_all_zero();
    test_two_pixel();
    test_last_pixel();
    test_ack_stress();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
